// File: rtl/apb_mem_slave_pkg.sv
// Shared types and helpers for the APB4 wait-state memory slave.
package apb_mem_slave_pkg;

  // Two-state transfer FSM: waiting for a setup cycle, or inside the access phase.
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // Bit positions of the individual error causes inside the captured error vector.
  typedef enum logic [1:0] {
    DECERR   = 2'd0,  // address beyond the memory
    ALIGNERR = 2'd1,  // byte address not word aligned
    PROTERR  = 2'd2,  // unprivileged access while privileged-only
    STRBERR  = 2'd3   // read issued with non-zero strobes
  } err_cause_e;

  localparam int ERR_W = 4;

  // Number of byte-offset address bits below the word index.
  function automatic int ofs_w(input int strb_wd);
    return $clog2(strb_wd);
  endfunction

  // Number of address bits needed to index MEM_DEPTH words.
  function automatic int idx_w(input int mem_depth);
    return $clog2(mem_depth);
  endfunction

endpackage

// File: rtl/apb_mem_slave_ws_bank.sv
// Byte-enable single-port memory: synchronous per-lane write, asynchronous read.
// The caller registers the read data; contents are never reset.
module apb_mem_bank
  import apb_mem_slave_pkg::*;
#(
  parameter int DATA_WD   = 32,
  parameter int MEM_DEPTH = 256,
  parameter int STRB_WD   = DATA_WD / 8,
  parameter int IDX_W     = idx_w(MEM_DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [STRB_WD-1:0] be,
  input  logic [IDX_W-1:0]   addr,
  input  logic [DATA_WD-1:0] wdata,
  output logic [DATA_WD-1:0] rdata
);

  logic [DATA_WD-1:0] mem [MEM_DEPTH];

  // Lane-wise write: only enabled byte lanes of the addressed word change.
  always_ff @(posedge clk) begin
    for (int k = 0; k < STRB_WD; k++) begin
      if (we && be[k]) begin
        mem[addr][k*8 +: 8] <= wdata[k*8 +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/apb_mem_slave_ws.sv
// APB4 memory slave with independent read/write wait states, byte-strobe
// writes, PSLVERR on decode/alignment/protection/strobe violations and a
// registered read path. DATA_WD must be 8, 16, 32 or 64; MEM_DEPTH a power
// of two (>= 2); WAIT_RD/WAIT_WR in 0..15.
module apb_mem_slave_ws
  import apb_mem_slave_pkg::*;
#(
  parameter int ADDR_WD   = 32,
  parameter int DATA_WD   = 32,
  parameter int STRB_WD   = DATA_WD / 8,
  parameter int PROT_WD   = 3,
  parameter int MEM_DEPTH = 256,
  parameter int WAIT_RD   = 1,
  parameter int WAIT_WR   = 0,
  parameter int PRIV_ONLY = 0
) (
  input  logic               b_pclk,
  input  logic               b_prst,
  input  logic               b_psel,
  input  logic               b_penable,
  input  logic               b_pwrite,
  input  logic [ADDR_WD-1:0] b_paddr,
  input  logic [DATA_WD-1:0] b_pwdata,
  input  logic [PROT_WD-1:0] b_pprot,
  input  logic [STRB_WD-1:0] b_pstrb,
  output logic [DATA_WD-1:0] b_prdata,
  output logic               b_pready,
  output logic               b_pslverr
);

  localparam int OFS   = ofs_w(STRB_WD);
  localparam int IDX_W = idx_w(MEM_DEPTH);

  // Byte-address limit is one bit wider than the bus so the compare cannot wrap.
  localparam logic [ADDR_WD:0]   ADDR_LIMIT = (ADDR_WD+1)'(MEM_DEPTH * STRB_WD);
  // Mask of the sub-word byte-offset bits; all-zero when the word is one byte.
  localparam logic [ADDR_WD-1:0] ALIGN_MASK = ADDR_WD'(STRB_WD - 1);

  state_e             state;
  logic [3:0]         cnt_p1;
  logic [ERR_W-1:0]   err_p1;
  logic               write_p1;
  logic [IDX_W-1:0]   idx_p1;
  logic [DATA_WD-1:0] rdata_p1;
  logic               ready_p1;
  logic               slverr_p1;

  logic [ERR_W-1:0]   err_p0;
  logic [IDX_W-1:0]   idx_p0;
  logic [3:0]         wait_p0;
  logic               setup_p0;
  logic               done_p0;
  logic [IDX_W-1:0]   bank_addr;
  logic               bank_we;
  logic [DATA_WD-1:0] bank_rdata;
  logic               unused_prot;

  // ---- setup-phase decode (combinational, consumed at the setup edge) ----
  assign idx_p0   = b_paddr[OFS +: IDX_W];
  assign wait_p0  = b_pwrite ? 4'(WAIT_WR) : 4'(WAIT_RD);
  assign setup_p0 = b_psel & ~b_penable;
  // ready_p1 is only ever set in ACCESS, so this marks the completion edge.
  assign done_p0  = b_psel & b_penable & ready_p1;

  // Only pprot[0] carries meaning here; the remaining bits are intentionally ignored.
  assign unused_prot = &{1'b0, b_pprot};

  // Classify the transfer presented in the setup cycle.
  always_comb begin
    err_p0           = '0;
    err_p0[DECERR]   = ({1'b0, b_paddr} >= ADDR_LIMIT);
    err_p0[ALIGNERR] = |(b_paddr & ALIGN_MASK);
    err_p0[PROTERR]  = (PRIV_ONLY != 0) && !b_pprot[0];
    err_p0[STRBERR]  = !b_pwrite && (b_pstrb != '0);
  end

  // Single port: the setup address reads in IDLE, the captured index writes in ACCESS.
  assign bank_addr = (state == ACCESS) ? idx_p1 : idx_p0;
  // Commit only on a clean completion; a reset on that edge drops the write.
  assign bank_we   = (state == ACCESS) && done_p0 && write_p1 && (err_p1 == '0) && !b_prst;

  apb_mem_bank #(
    .DATA_WD  (DATA_WD),
    .MEM_DEPTH(MEM_DEPTH),
    .STRB_WD  (STRB_WD),
    .IDX_W    (IDX_W)
  ) u_bank (
    .clk  (b_pclk),
    .we   (bank_we),
    .be   (b_pstrb),
    .addr (bank_addr),
    .wdata(b_pwdata),
    .rdata(bank_rdata)
  );

  // ---- access phase: transfer FSM with registered ready/error/read data ----
  always_ff @(posedge b_pclk) begin
    if (b_prst) begin
      state     <= IDLE;
      cnt_p1    <= '0;
      err_p1    <= '0;
      write_p1  <= 1'b0;
      idx_p1    <= '0;
      rdata_p1  <= '0;
      ready_p1  <= 1'b0;
      slverr_p1 <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready_p1  <= 1'b0;
          slverr_p1 <= 1'b0;
          rdata_p1  <= '0;
          if (setup_p0) begin
            state     <= ACCESS;
            cnt_p1    <= wait_p0;
            err_p1    <= err_p0;
            write_p1  <= b_pwrite;
            idx_p1    <= idx_p0;
            rdata_p1  <= (!b_pwrite && (err_p0 == '0)) ? bank_rdata : '0;
            ready_p1  <= (wait_p0 == 4'd0);
            slverr_p1 <= (wait_p0 == 4'd0) && (err_p0 != '0);
          end
        end
        ACCESS: begin
          if (!b_psel || done_p0) begin
            // Abort or completion: return to idle with outputs cleared.
            state     <= IDLE;
            cnt_p1    <= '0;
            rdata_p1  <= '0;
            ready_p1  <= 1'b0;
            slverr_p1 <= 1'b0;
          end else if (cnt_p1 != 4'd0) begin
            cnt_p1    <= cnt_p1 - 4'd1;
            ready_p1  <= (cnt_p1 == 4'd1);
            slverr_p1 <= (cnt_p1 == 4'd1) && (err_p1 != '0);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign b_prdata  = rdata_p1;
  assign b_pready  = ready_p1;
  assign b_pslverr = slverr_p1;

endmodule

// File: tb/tb_apb_mem_slave_ws.sv
// Directed bench for apb_mem_slave_ws: three instances (default, privileged-only,
// WAIT_WR=3) share the bus; a queue holds the expected completion of each transfer.
module tb_apb_mem_slave_ws;

  logic        b_pclk = 1'b0;
  logic        b_prst = 1'b1;
  logic [2:0]  psel_v = '0;
  logic        b_penable = 1'b0;
  logic        b_pwrite = 1'b0;
  logic [31:0] b_paddr = '0;
  logic [31:0] b_pwdata = '0;
  logic [2:0]  b_pprot = '0;
  logic [3:0]  b_pstrb = '0;

  logic [31:0] prdata_w [3];
  logic [2:0]  pready_w;
  logic [2:0]  pslverr_w;

  logic [31:0] prdata_m;
  logic        pready_m;
  logic        pslverr_m;
  int          cur = 0;

  typedef struct {
    int          ncyc;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [3][256];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 b_pclk = ~b_pclk;

  apb_mem_slave_ws u_def (
    .b_pclk(b_pclk), .b_prst(b_prst), .b_psel(psel_v[0]), .b_penable(b_penable),
    .b_pwrite(b_pwrite), .b_paddr(b_paddr), .b_pwdata(b_pwdata), .b_pprot(b_pprot),
    .b_pstrb(b_pstrb), .b_prdata(prdata_w[0]), .b_pready(pready_w[0]), .b_pslverr(pslverr_w[0])
  );

  apb_mem_slave_ws #(.PRIV_ONLY(1)) u_priv (
    .b_pclk(b_pclk), .b_prst(b_prst), .b_psel(psel_v[1]), .b_penable(b_penable),
    .b_pwrite(b_pwrite), .b_paddr(b_paddr), .b_pwdata(b_pwdata), .b_pprot(b_pprot),
    .b_pstrb(b_pstrb), .b_prdata(prdata_w[1]), .b_pready(pready_w[1]), .b_pslverr(pslverr_w[1])
  );

  apb_mem_slave_ws #(.WAIT_WR(3)) u_ws (
    .b_pclk(b_pclk), .b_prst(b_prst), .b_psel(psel_v[2]), .b_penable(b_penable),
    .b_pwrite(b_pwrite), .b_paddr(b_paddr), .b_pwdata(b_pwdata), .b_pprot(b_pprot),
    .b_pstrb(b_pstrb), .b_prdata(prdata_w[2]), .b_pready(pready_w[2]), .b_pslverr(pslverr_w[2])
  );

  always_comb begin
    prdata_m  = prdata_w[0];
    pready_m  = pready_w[0];
    pslverr_m = pslverr_w[0];
    case (cur)
      1: begin prdata_m = prdata_w[1]; pready_m = pready_w[1]; pslverr_m = pslverr_w[1]; end
      2: begin prdata_m = prdata_w[2]; pready_m = pready_w[2]; pslverr_m = pslverr_w[2]; end
      default: ;
    endcase
  end

  task automatic step();
    @(posedge b_pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s (dut %0d): observed 0x%0h expected 0x%0h", tag, cur, obs, exp);
    end
  endtask

  // One complete transfer on instance d; expectations come from the bench model.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb, input logic [2:0] prot);
    exp_t e;
    exp_t got;
    int   n;
    int   idx;
    bit   err;
    idx = int'(addr[9:2]);
    err = (addr >= 32'h400) || (addr[1:0] != 2'b00) || (d == 1 && !prot[0]) ||
          (!wr && strb != 4'h0);
    e.ncyc  = wr ? ((d == 2) ? 4 : 1) : 2;
    e.err   = err;
    e.rdata = (wr || err) ? 32'h0 : mdl[d][idx];
    sb.push_back(e);

    cur       = d;
    psel_v    = 3'b001 << d;
    b_penable = 1'b0;
    b_pwrite  = wr;
    b_paddr   = addr;
    b_pwdata  = data;
    b_pstrb   = strb;
    b_pprot   = prot;
    step();
    b_penable = 1'b1;
    n = 1;
    while (!pready_m && n < 20) begin
      chk("wait_pslverr", 64'(pslverr_m), 64'(0));
      if (!wr) chk("rdata_during_wait", 64'(prdata_m), 64'(e.rdata));
      step();
      n++;
    end
    got = sb.pop_front();
    chk("access_cycles", 64'(n), 64'(got.ncyc));
    chk("pready", 64'(pready_m), 64'(1));
    chk("pslverr", 64'(pslverr_m), 64'(got.err));
    chk("prdata", 64'(prdata_m), 64'(got.rdata));
    if (wr && !err) begin
      for (int k = 0; k < 4; k++) begin
        if (strb[k]) mdl[d][idx][k*8 +: 8] = data[k*8 +: 8];
      end
    end
    step();
    chk("post_pready", 64'(pready_m), 64'(0));
    chk("post_prdata", 64'(prdata_m), 64'(0));
    psel_v    = '0;
    b_penable = 1'b0;
  endtask

  initial begin
    // Reset: all instances come up with outputs at zero.
    b_prst = 1'b1;
    step();
    step();
    for (int d = 0; d < 3; d++) begin
      cur = d;
      #0;
      chk("rst_pready", 64'(pready_m), 64'(0));
      chk("rst_pslverr", 64'(pslverr_m), 64'(0));
      chk("rst_prdata", 64'(prdata_m), 64'(0));
    end
    b_prst = 1'b0;
    step();

    // Default waits: write completes in 1 access cycle, read in 2.
    xfer(0, 1, 32'h10, 32'hA5A5_1234, 4'hF, 3'b000);
    xfer(0, 0, 32'h10, 32'h0, 4'h0, 3'b000);
    // Partial strobes merge into the existing word.
    xfer(0, 1, 32'h10, 32'hFFFF_FFFF, 4'b0101, 3'b000);
    xfer(0, 0, 32'h10, 32'h0, 4'h0, 3'b000);
    chk("merged_word_model", 64'(mdl[0][4]), 64'(32'hA5FF_12FF));
    // Zero-strobe write is legal and changes nothing.
    xfer(0, 1, 32'h10, 32'h0000_0000, 4'h0, 3'b000);
    xfer(0, 0, 32'h10, 32'h0, 4'h0, 3'b000);
    // Decode error on read and on misaligned/out-of-range write.
    xfer(0, 0, 32'h400, 32'h0, 4'h0, 3'b000);
    xfer(0, 1, 32'h0, 32'h1122_3344, 4'hF, 3'b000);
    xfer(0, 1, 32'h402, 32'h0000_07FF, 4'hF, 3'b000);
    xfer(0, 0, 32'h0, 32'h0, 4'h0, 3'b000);
    // Misaligned read and read with strobes set are both rejected.
    xfer(0, 0, 32'h12, 32'h0, 4'h0, 3'b000);
    xfer(0, 0, 32'h10, 32'h0, 4'h1, 3'b000);

    // Privileged-only instance.
    xfer(1, 1, 32'h20, 32'hCAFE_0001, 4'hF, 3'b001);
    xfer(1, 1, 32'h20, 32'h5555_AAAA, 4'hF, 3'b000);
    xfer(1, 0, 32'h20, 32'h0, 4'h0, 3'b001);
    xfer(1, 1, 32'h20, 32'h5555_AAAA, 4'hF, 3'b001);
    xfer(1, 0, 32'h20, 32'h0, 4'h0, 3'b001);
    xfer(1, 0, 32'h20, 32'h0, 4'h0, 3'b000);

    // WAIT_WR=3: back-to-back writes, 4 access cycles each, then read back.
    xfer(2, 1, 32'h0, 32'h0BAD_F00D, 4'hF, 3'b000);
    xfer(2, 1, 32'h4, 32'h600D_CAFE, 4'hF, 3'b000);
    xfer(2, 0, 32'h0, 32'h0, 4'h0, 3'b000);
    xfer(2, 0, 32'h4, 32'h0, 4'h0, 3'b000);

    // Abort: psel drops mid-wait, nothing is written.
    cur = 2;
    psel_v = 3'b100; b_penable = 1'b0; b_pwrite = 1'b1; b_paddr = 32'h4;
    b_pwdata = 32'hFFFF_0000; b_pstrb = 4'hF; b_pprot = 3'b000;
    step();
    b_penable = 1'b1;
    step();
    psel_v = '0; b_penable = 1'b0;
    step();
    chk("abort_pready", 64'(pready_m), 64'(0));
    chk("abort_prdata", 64'(prdata_m), 64'(0));
    xfer(2, 0, 32'h4, 32'h0, 4'h0, 3'b000);

    // Reset during the second wait cycle of a write drops the write.
    psel_v = 3'b100; b_penable = 1'b0; b_pwrite = 1'b1; b_paddr = 32'h0;
    b_pwdata = 32'hDEAD_BEEF; b_pstrb = 4'hF; b_pprot = 3'b000;
    step();
    b_penable = 1'b1;
    step();
    b_prst = 1'b1;
    step();
    chk("midrst_pready", 64'(pready_m), 64'(0));
    chk("midrst_pslverr", 64'(pslverr_m), 64'(0));
    chk("midrst_prdata", 64'(prdata_m), 64'(0));
    b_prst = 1'b0; psel_v = '0; b_penable = 1'b0;
    step();
    xfer(2, 0, 32'h0, 32'h0, 4'h0, 3'b000);
    xfer(2, 1, 32'h8, 32'h1234_5678, 4'hF, 3'b000);
    xfer(2, 0, 32'h8, 32'h0, 4'h0, 3'b000);

    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
